mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter IMEM_WORDS, default 128: instruction-memory depth in 32-bit words, power of two.
REQ-002 Parameter DMEM_WORDS, default 128: data-memory depth in 32-bit words, power of two.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 pc_out  in  32  instruction byte address.
REQ-006 IM_R  in  1  instruction read request.
REQ-007 inst  out  32  registered instruction word.
REQ-008 maddr  in  32  data byte address.
REQ-009 mwdata  in  32  data write word.
REQ-010 DM_CS  in  1  data-memory chip select.
REQ-011 DM_R  in  1  data read request, qualified by DM_CS.
REQ-012 DM_W  in  1  data write request, qualified by DM_CS.
REQ-013 mrdata  out  32  registered data read word.
REQ-014 prog_we  in  1  program-load write strobe for instruction memory.
REQ-015 prog_addr  in  32  program-load byte address.
REQ-016 prog_wdata  in  32  program-load word.
REQ-017 mem_ready  out  1  high once data-memory clear sweep is complete.
REQ-018 addr_err  out  1  sticky misaligned/out-of-range access flag.

Function
REQ-019 FSM states: CLEAR and READY; reset forces CLEAR with clear pointer = 0.
REQ-020 CLEAR: each cycle writes 0 to dmem[ptr] and increments ptr; the cycle ptr == DMEM_WORDS-1 is written, FSM moves to READY; sweep lasts exactly DMEM_WORDS cycles.
REQ-021 mem_ready = 1 only in READY; READY is held until reset.
REQ-022 Instruction fetch, word index = pc_out[2 +: log2(IMEM_WORDS)]: IM_R=1 at an edge loads inst with imem[index] (1-cycle latency); IM_R=0 holds inst.
REQ-023 Instruction fetch works in both FSM states; imem contents are never cleared by reset or sweep.
REQ-024 prog_we=1 writes prog_wdata to imem[prog_addr index] at the edge, in either state; same-edge fetch of the same index returns the old word.
REQ-025 Data index = maddr[2 +: log2(DMEM_WORDS)]; a data access is valid when DM_CS=1, maddr[1:0]=0, and maddr upper bits beyond the index are 0.
REQ-026 READY, valid, DM_W=1: dmem[index] <= mwdata at the edge.
REQ-027 READY, valid, DM_R=1: mrdata <= dmem[index] (1-cycle latency); DM_R=0 or DM_CS=0 holds mrdata.
REQ-028 DM_R and DM_W both high: write performed; mrdata returns the pre-write word (read-before-write).
REQ-029 In CLEAR, data requests are ignored: no write, mrdata held at 0, no error flagged.
REQ-030 READY, DM_CS=1 with (DM_R or DM_W) and invalid address: no write, mrdata <= 0, addr_err set.
REQ-031 Fetch with IM_R=1 and misaligned or out-of-range pc_out: inst <= 0, addr_err set.
REQ-032 addr_err, once set, remains 1 until reset.

Reset
REQ-033 While reset=1 at an edge: inst=0, mrdata=0, addr_err=0, mem_ready=0, FSM=CLEAR, ptr=0.
REQ-034 Reset asserted mid-sweep or mid-access restarts the sweep from ptr 0; a write presented on a reset edge is discarded.

Structure
REQ-035 Shared package mem_responder_pkg holds the FSM state typedef (CLEAR, READY) and default depth constants.
REQ-036 One sub-module, sync_ram (one write port, one registered read port, read-before-write), is instantiated twice: imem and dmem.

Verification
REQ-037 Reset, then count cycles: mem_ready rises exactly 128 cycles after reset deasserts; all dmem words read back 0.
REQ-038 prog_we writes 0x3C010001 at prog_addr 0x0; IM_R=1, pc_out=0x0 -> inst = 0x3C010001 on the next edge.
REQ-039 READY: DM_W with maddr=0x10, mwdata=0xDEADBEEF; then DM_R at 0x10 -> mrdata = 0xDEADBEEF after 1 cycle.
REQ-040 Simultaneous DM_R/DM_W at 0x10 with mwdata=0x12345678 -> mrdata = 0xDEADBEEF; next read returns 0x12345678.
REQ-041 DM_W at maddr=0x13, then at maddr=0x400 -> no write at either, mrdata = 0, addr_err = 1 and held until reset.
REQ-042 DM_W at maddr=0x20 during CLEAR -> ignored; reset at sweep cycle 50 -> mem_ready rises 128 cycles after reset deasserts.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// ---------------------------------------------------------------------------
// Module   : mem_responder_pkg
// Purpose  : Shared FSM state type and default memory depths for mem_responder.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mem_responder_pkg;

   typedef logic [0:0] state_t;

   localparam state_t ST_CLEAR = 1'b0;
   localparam state_t ST_READY = 1'b1;

   localparam int DEF_IMEM_WORDS = 128;
   localparam int DEF_DMEM_WORDS = 128;

endpackage : mem_responder_pkg

`default_nettype wire

// File: rtl/mem_responder_if.sv
// ---------------------------------------------------------------------------
// Module   : mem_responder_if
// Purpose  : Instruction, data and program-load bus between a core and mem_responder.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface mem_responder_if;

   logic [31:0] pc_out;
   logic        IM_R;
   logic [31:0] inst;
   logic [31:0] maddr;
   logic [31:0] mwdata;
   logic        DM_CS;
   logic        DM_R;
   logic        DM_W;
   logic [31:0] mrdata;
   logic        prog_we;
   logic [31:0] prog_addr;
   logic [31:0] prog_wdata;
   logic        mem_ready;
   logic        addr_err;

   modport master (
      output pc_out, IM_R, maddr, mwdata, DM_CS, DM_R, DM_W,
             prog_we, prog_addr, prog_wdata,
      input  inst, mrdata, mem_ready, addr_err
   );

   modport slave (
      input  pc_out, IM_R, maddr, mwdata, DM_CS, DM_R, DM_W,
             prog_we, prog_addr, prog_wdata,
      output inst, mrdata, mem_ready, addr_err
   );

endinterface : mem_responder_if

`default_nettype wire

// File: rtl/mem_responder_sync_ram.sv
// ---------------------------------------------------------------------------
// Module   : sync_ram
// Purpose  : Single write port, registered read port RAM with read-before-write.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync_ram #(
   parameter  int WORDS = 128,
   parameter  int WIDTH = 32,
   localparam int AW    = $clog2(WORDS)
) (
   input  wire logic             clk,
   input  wire logic             rst_i,
   input  wire logic             we_i,
   input  wire logic [AW-1:0]    waddr_i,
   input  wire logic [WIDTH-1:0] wdata_i,
   input  wire logic             re_i,
   input  wire logic             rclr_i,
   input  wire logic [AW-1:0]    raddr_i,
   output logic      [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [WORDS];
   logic [WIDTH-1:0] rdata_q;

   // Array contents are deliberately not reset; only the read register is.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_i || rclr_i) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule : sync_ram

`default_nettype wire

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// Module   : mem_responder
// Purpose  : Instruction/data memory responder with power-up data-memory clear sweep.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int IMEM_WORDS = DEF_IMEM_WORDS,
   parameter int DMEM_WORDS = DEF_DMEM_WORDS
) (
   input wire logic         clk,
   input wire logic         reset,
   mem_responder_if.slave   bus
);

   localparam int IAW = $clog2(IMEM_WORDS);
   localparam int DAW = $clog2(DMEM_WORDS);

   state_t         state_q, state_d;
   logic [DAW-1:0] ptr_q, ptr_d;
   logic           err_q, err_d;

   logic [IAW-1:0] i_idx, p_idx;
   logic [DAW-1:0] d_idx;
   logic           i_valid, p_valid, d_valid, d_req, ready;

   logic           dm_we;
   logic [DAW-1:0] dm_waddr;
   logic [31:0]    dm_wdata;
   logic [31:0]    im_rdata, dm_rdata;

   assign ready   = (state_q == ST_READY);

   assign i_idx   = bus.pc_out[2 +: IAW];
   assign i_valid = (bus.pc_out[1:0] == 2'b00) && ((bus.pc_out >> (IAW + 2)) == 32'd0);

   // Program loads outside the instruction window are dropped rather than aliased.
   assign p_idx   = bus.prog_addr[2 +: IAW];
   assign p_valid = (bus.prog_addr[1:0] == 2'b00) && ((bus.prog_addr >> (IAW + 2)) == 32'd0);

   assign d_idx   = bus.maddr[2 +: DAW];
   assign d_valid = bus.DM_CS && (bus.maddr[1:0] == 2'b00) && ((bus.maddr >> (DAW + 2)) == 32'd0);
   assign d_req   = bus.DM_CS && (bus.DM_R || bus.DM_W);

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      if (state_q == ST_CLEAR) begin
         ptr_d = ptr_q + 1'b1;
         if (ptr_q == DAW'(DMEM_WORDS - 1)) begin
            state_d = ST_READY;
         end
      end
   end

   always_comb begin
      err_d = err_q;
      if ((ready && d_req && !d_valid) || (bus.IM_R && !i_valid)) begin
         err_d = 1'b1;
      end
   end

   // The sweep owns the dmem write port until READY; reset-edge writes are discarded.
   always_comb begin
      dm_we    = 1'b0;
      dm_waddr = d_idx;
      dm_wdata = bus.mwdata;
      if (!reset) begin
         if (state_q == ST_CLEAR) begin
            dm_we    = 1'b1;
            dm_waddr = ptr_q;
            dm_wdata = '0;
         end else begin
            dm_we    = d_valid && bus.DM_W;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_CLEAR;
         ptr_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         err_q   <= err_d;
      end
   end

   sync_ram #(
      .WORDS (IMEM_WORDS),
      .WIDTH (32)
   ) u_imem (
      .clk     (clk),
      .rst_i   (reset),
      .we_i    (bus.prog_we && p_valid && !reset),
      .waddr_i (p_idx),
      .wdata_i (bus.prog_wdata),
      .re_i    (bus.IM_R && i_valid),
      .rclr_i  (bus.IM_R && !i_valid),
      .raddr_i (i_idx),
      .rdata_o (im_rdata)
   );

   sync_ram #(
      .WORDS (DMEM_WORDS),
      .WIDTH (32)
   ) u_dmem (
      .clk     (clk),
      .rst_i   (reset),
      .we_i    (dm_we),
      .waddr_i (dm_waddr),
      .wdata_i (dm_wdata),
      .re_i    (ready && d_valid && bus.DM_R),
      .rclr_i  (ready && d_req && !d_valid),
      .raddr_i (d_idx),
      .rdata_o (dm_rdata)
   );

   assign bus.inst      = im_rdata;
   assign bus.mrdata    = dm_rdata;
   assign bus.mem_ready = ready;
   assign bus.addr_err  = err_q;

endmodule : mem_responder

`default_nettype wire

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// Module   : tb_mem_responder
// Purpose  : Directed, table-driven self-checking bench for mem_responder.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_responder;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   mem_responder_if bus ();

   mem_responder #(
      .IMEM_WORDS (128),
      .DMEM_WORDS (128)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [31:0] pc;
      logic        imr;
      logic [31:0] ma;
      logic [31:0] wd;
      logic        cs;
      logic        r;
      logic        w;
      logic        pwe;
      logic [31:0] pa;
      logic [31:0] pd;
      logic [31:0] e_inst;
      logic [31:0] e_mr;
      logic        e_err;
   } vec_t;

   vec_t vt [15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.pc_out = '0; bus.IM_R = 1'b0;
      bus.maddr = '0; bus.mwdata = '0;
      bus.DM_CS = 1'b0; bus.DM_R = 1'b0; bus.DM_W = 1'b0;
      bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_wdata = '0;
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic dacc(input logic [31:0] a, input logic [31:0] d, input logic r, input logic w);
      idle_inputs();
      bus.DM_CS = 1'b1; bus.maddr = a; bus.mwdata = d; bus.DM_R = r; bus.DM_W = w;
      cyc();
   endtask

   task automatic fetch(input logic [31:0] pc);
      idle_inputs();
      bus.IM_R = 1'b1; bus.pc_out = pc;
      cyc();
   endtask

   // Counts edges after reset release until mem_ready; optionally pokes a CLEAR-time write.
   task automatic wait_ready(input bit inject, output int n);
      n = 0;
      for (int i = 1; i <= 400; i++) begin
         idle_inputs();
         if (inject && i >= 20 && i <= 25) begin
            bus.DM_CS = 1'b1; bus.DM_W = 1'b1; bus.DM_R = 1'b1;
            bus.maddr = 32'h20; bus.mwdata = 32'hCAFEF00D;
         end
         cyc();
         if (inject && i >= 20 && i <= 25) begin
            chk("clear_req_mrdata", bus.mrdata, 32'h0);
            chk("clear_req_err", {31'b0, bus.addr_err}, 32'h0);
         end
         if (bus.mem_ready) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_inst"},  bus.inst, 32'h0);
      chk({tag, "_mrdata"}, bus.mrdata, 32'h0);
      chk({tag, "_err"},   {31'b0, bus.addr_err}, 32'h0);
      chk({tag, "_ready"}, {31'b0, bus.mem_ready}, 32'h0);
   endtask

   initial begin
      int n;
      checks = 0;
      errors = 0;
      idle_inputs();
      reset = 1'b1;

      vt[0]  = '{32'h0,   1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h3C010001, 32'h0,        32'h0,        1'b0};
      vt[1]  = '{32'h0,   1'b1, 32'h0,   32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,        32'h3C010001, 32'h0,        1'b0};
      vt[2]  = '{32'h0,   1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h4, 32'hAAAA5555, 32'h3C010001, 32'h0,        1'b0};
      vt[3]  = '{32'h4,   1'b1, 32'h0,   32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h4, 32'h11112222, 32'hAAAA5555, 32'h0,        1'b0};
      vt[4]  = '{32'h4,   1'b1, 32'h0,   32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,        32'h11112222, 32'h0,        1'b0};
      vt[5]  = '{32'h0,   1'b0, 32'h10,  32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0,        32'h11112222, 32'h0,        1'b0};
      vt[6]  = '{32'h0,   1'b0, 32'h10,  32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0,        32'h11112222, 32'hDEADBEEF, 1'b0};
      vt[7]  = '{32'h0,   1'b0, 32'h10,  32'h12345678, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0,        32'h11112222, 32'hDEADBEEF, 1'b0};
      vt[8]  = '{32'h0,   1'b0, 32'h10,  32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0,        32'h11112222, 32'h12345678, 1'b0};
      vt[9]  = '{32'h0,   1'b0, 32'h1FC, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0,        32'h11112222, 32'h12345678, 1'b0};
      vt[10] = '{32'h0,   1'b0, 32'h20,  32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0,        32'h11112222, 32'h0,        1'b0};
      vt[11] = '{32'h0,   1'b0, 32'h10,  32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0,        32'h11112222, 32'h12345678, 1'b0};
      vt[12] = '{32'h0,   1'b0, 32'h1FC, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0,        32'h11112222, 32'h0,        1'b0};
      vt[13] = '{32'h0,   1'b0, 32'h1FC, 32'h00000077, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0,        32'h11112222, 32'h0,        1'b0};
      vt[14] = '{32'h0,   1'b0, 32'h1FC, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0,        32'h11112222, 32'h00000077, 1'b0};

      // Reset state, then a CLEAR sweep aborted by reset at cycle 50.
      cyc(); cyc(); cyc();
      chk_reset_state("rst0");
      reset = 1'b0;
      for (int i = 1; i <= 50; i++) begin
         if (i <= 10) begin
            bus.DM_CS = 1'b1; bus.DM_W = 1'b1; bus.DM_R = 1'b1;
            bus.maddr = 32'h20; bus.mwdata = 32'h55AA55AA;
         end else begin
            idle_inputs();
         end
         cyc();
         if (i == 10) begin
            chk("clear_mrdata_held", bus.mrdata, 32'h0);
            chk("clear_no_err", {31'b0, bus.addr_err}, 32'h0);
            chk("clear_not_ready", {31'b0, bus.mem_ready}, 32'h0);
         end
      end
      idle_inputs();
      reset = 1'b1;
      cyc(); cyc();
      chk_reset_state("rst1");
      reset = 1'b0;
      wait_ready(1'b1, n);
      chk("sweep_len", n, 32'd128);

      for (int a = 0; a < 128; a++) begin
         dacc(32'(a * 4), 32'h0, 1'b1, 1'b0);
         chk($sformatf("dmem_zero_%0d", a), bus.mrdata, 32'h0);
      end

      for (int k = 0; k < 15; k++) begin
         idle_inputs();
         bus.pc_out = vt[k].pc;  bus.IM_R = vt[k].imr;
         bus.maddr = vt[k].ma;   bus.mwdata = vt[k].wd;
         bus.DM_CS = vt[k].cs;   bus.DM_R = vt[k].r;   bus.DM_W = vt[k].w;
         bus.prog_we = vt[k].pwe; bus.prog_addr = vt[k].pa; bus.prog_wdata = vt[k].pd;
         cyc();
         chk($sformatf("vec%0d_inst", k), bus.inst, vt[k].e_inst);
         chk($sformatf("vec%0d_mrdata", k), bus.mrdata, vt[k].e_mr);
         chk($sformatf("vec%0d_err", k), {31'b0, bus.addr_err}, {31'b0, vt[k].e_err});
         chk($sformatf("vec%0d_ready", k), {31'b0, bus.mem_ready}, 32'h1);
      end

      // Misaligned and out-of-range data writes must not land and must flag.
      dacc(32'h13, 32'h99, 1'b0, 1'b1);
      chk("mis_mrdata", bus.mrdata, 32'h0);
      chk("mis_err", {31'b0, bus.addr_err}, 32'h1);
      dacc(32'h10, 32'h0, 1'b1, 1'b0);
      chk("mis_nowrite", bus.mrdata, 32'h12345678);
      dacc(32'h400, 32'h88, 1'b0, 1'b1);
      chk("oor_mrdata", bus.mrdata, 32'h0);
      dacc(32'h10, 32'h0, 1'b1, 1'b0);
      chk("oor_reread", bus.mrdata, 32'h12345678);
      dacc(32'h0, 32'h0, 1'b1, 1'b0);
      chk("oor_nowrite", bus.mrdata, 32'h0);
      idle_inputs();
      for (int i = 0; i < 5; i++) cyc();
      chk("err_sticky", {31'b0, bus.addr_err}, 32'h1);

      reset = 1'b1;
      cyc(); cyc();
      chk_reset_state("rst2");
      reset = 1'b0;

      // Fetch during CLEAR, imem survives reset, then bad pc values.
      fetch(32'h0);
      chk("clr_fetch_inst", bus.inst, 32'h3C010001);
      chk("clr_fetch_err", {31'b0, bus.addr_err}, 32'h0);
      fetch(32'h2);
      chk("pc_mis_inst", bus.inst, 32'h0);
      chk("pc_mis_err", {31'b0, bus.addr_err}, 32'h1);
      fetch(32'h4);
      chk("refetch_inst", bus.inst, 32'h11112222);
      fetch(32'h200);
      chk("pc_oor_inst", bus.inst, 32'h0);
      chk("pc_oor_err", {31'b0, bus.addr_err}, 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_mem_responder

`default_nettype wire
